// File: rtl/dual_port_ram_pkg.sv
// Shared constants and types for the dual-port RAM and its clear sequencer.
package dual_port_ram_pkg;

  // Same-port read-during-write behaviour selectors.
  localparam string RDW_READ_FIRST  = "read_first";
  localparam string RDW_WRITE_FIRST = "write_first";

  // Power-up clear sequencer states.
  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage : dual_port_ram_pkg

// File: rtl/dual_port_ram_if.sv
// One RAM access port: request, byte-masked write data and read return.
interface dual_port_ram_if
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                  en_i;
  logic                  wr_i;
  logic [NB-1:0]         byte_valid_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;

  // Requester side.
  modport master (
    output en_i, wr_i, byte_valid_i, addr_i, data_i,
    input  data_o, valid_o
  );

  // RAM side.
  modport slave (
    input  en_i, wr_i, byte_valid_i, addr_i, data_i,
    output data_o, valid_o
  );

endinterface : dual_port_ram_if

// File: rtl/ram_clear_fsm.sv
// Walks every address once after reset so the array starts at zero.
module ram_clear_fsm
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          CLEAR_EN   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam clr_state_e            RST_STATE = CLEAR_EN ? CLR_CLEAR : CLR_DONE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  // Clear sequencer: one address per cycle, then parked in DONE until reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= CLEAR_EN;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          state_q <= RST_STATE;
          cnt_q   <= '0;
          busy_q  <= CLEAR_EN;
        end
        CLR_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= CLR_DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        CLR_DONE: begin
          state_q <= CLR_DONE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= CLR_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_addr_o = cnt_q;

endmodule : ram_clear_fsm

// File: rtl/dual_port_ram.sv
// True dual-port byte-writable RAM with 1- or 2-cycle registered read return.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned OUT_LATENCY = 1,
  parameter string       RDW_MODE    = RDW_READ_FIRST,
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  dual_port_ram_if.slave   a_if,
  dual_port_ram_if.slave   b_if,
  output logic             busy_o
);

  localparam int unsigned NB          = DATA_WIDTH / 8;
  localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
  localparam bit          WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);
  localparam bit          CLEAR_EN    = (INIT_FILE == "");

  // Parameter legality.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_dw
    $fatal(1, "dual_port_ram: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (OUT_LATENCY != 1 && OUT_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "dual_port_ram: OUT_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $fatal(1, "dual_port_ram: RDW_MODE must be read_first or write_first");
  end

  typedef logic [NB-1:0][7:0] word_t;

  word_t                 mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  a_acc_c, b_acc_c;
  word_t                 a_din_c, b_din_c;
  word_t                 a_old_c, b_old_c;
  word_t                 a_merged_c, b_merged_c;
  word_t                 a_rd_c, b_rd_c;
  logic [NB-1:0]         a_we_c, b_we_c;
  logic [ADDR_WIDTH-1:0] a_waddr_c;
  word_t                 a_wdata_c;

  word_t                 a_s1_q, b_s1_q;
  logic                  a_v1_q, b_v1_q;

  ram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CLEAR_EN   (CLEAR_EN)
  ) u_clr (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .busy_o     (busy_o),
    .clr_addr_o (clr_addr)
  );

  assign a_acc_c = a_if.en_i & ~busy_o;
  assign b_acc_c = b_if.en_i & ~busy_o;
  assign a_din_c = a_if.data_i;
  assign b_din_c = b_if.data_i;

  // Port A read word: old contents, or own-write merged on top for write_first.
  always_comb begin
    a_old_c    = mem_q[a_if.addr_i];
    a_merged_c = a_old_c;
    for (int i = 0; i < int'(NB); i++) begin
      if (a_if.wr_i && a_if.byte_valid_i[i]) a_merged_c[i] = a_din_c[i];
    end
    a_rd_c = WRITE_FIRST ? a_merged_c : a_old_c;
  end

  // Port B read word: old contents, or own-write merged on top for write_first.
  always_comb begin
    b_old_c    = mem_q[b_if.addr_i];
    b_merged_c = b_old_c;
    for (int i = 0; i < int'(NB); i++) begin
      if (b_if.wr_i && b_if.byte_valid_i[i]) b_merged_c[i] = b_din_c[i];
    end
    b_rd_c = WRITE_FIRST ? b_merged_c : b_old_c;
  end

  // Port A write path is borrowed by the clear sequencer while busy.
  always_comb begin
    a_we_c    = '0;
    a_waddr_c = a_if.addr_i;
    a_wdata_c = a_din_c;
    if (busy_o) begin
      a_we_c    = '1;
      a_waddr_c = clr_addr;
      a_wdata_c = '0;
    end else if (a_acc_c && a_if.wr_i) begin
      a_we_c    = a_if.byte_valid_i;
    end
  end

  assign b_we_c = (b_acc_c && b_if.wr_i) ? b_if.byte_valid_i : '0;

  // Storage array: two byte-masked write ports, A written last so it wins overlaps.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NB); i++) begin
      if (b_we_c[i]) mem_q[b_if.addr_i][i] <= b_din_c[i];
      if (a_we_c[i]) mem_q[a_waddr_c][i]   <= a_wdata_c[i];
    end
  end

  // First output stage: capture read word on every accepted access, hold otherwise.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      a_v1_q <= 1'b0;
      a_s1_q <= '0;
      b_v1_q <= 1'b0;
      b_s1_q <= '0;
    end else begin
      a_v1_q <= a_acc_c;
      b_v1_q <= b_acc_c;
      if (a_acc_c) a_s1_q <= a_rd_c;
      if (b_acc_c) b_s1_q <= b_rd_c;
    end
  end

  if (OUT_LATENCY == 2) begin : g_lat2
    word_t a_s2_q, b_s2_q;
    logic  a_v2_q, b_v2_q;

    // Second output stage: fully pipelined, advances whenever stage one is valid.
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        a_v2_q <= 1'b0;
        a_s2_q <= '0;
        b_v2_q <= 1'b0;
        b_s2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_s2_q <= a_s1_q;
        if (b_v1_q) b_s2_q <= b_s1_q;
      end
    end

    assign a_if.data_o  = a_s2_q;
    assign a_if.valid_o = a_v2_q;
    assign b_if.data_o  = b_s2_q;
    assign b_if.valid_o = b_v2_q;
  end else begin : g_lat1
    assign a_if.data_o  = a_s1_q;
    assign a_if.valid_o = a_v1_q;
    assign b_if.data_o  = b_s1_q;
    assign b_if.valid_o = b_v1_q;
  end

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// Directed bench: one read_first/latency-1 RAM and one write_first/latency-2 RAM
// driven with identical stimulus.
module tb_dual_port_ram;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic          a_en, a_wr, b_en, b_wr;
  logic [3:0]    a_bv, b_bv;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_d, b_d;
  logic          busy1, busy2;

  logic [31:0] model [16];
  int checks = 0;
  int failures = 0;

  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia1 ();
  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib1 ();
  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia2 ();
  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib2 ();

  assign ia1.en_i = a_en;  assign ia1.wr_i = a_wr;  assign ia1.byte_valid_i = a_bv;
  assign ia1.addr_i = a_addr;  assign ia1.data_i = a_d;
  assign ia2.en_i = a_en;  assign ia2.wr_i = a_wr;  assign ia2.byte_valid_i = a_bv;
  assign ia2.addr_i = a_addr;  assign ia2.data_i = a_d;
  assign ib1.en_i = b_en;  assign ib1.wr_i = b_wr;  assign ib1.byte_valid_i = b_bv;
  assign ib1.addr_i = b_addr;  assign ib1.data_i = b_d;
  assign ib2.en_i = b_en;  assign ib2.wr_i = b_wr;  assign ib2.byte_valid_i = b_bv;
  assign ib2.addr_i = b_addr;  assign ib2.data_i = b_d;

  dual_port_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .OUT_LATENCY (1),
    .RDW_MODE ("read_first"), .INIT_FILE ("")
  ) u_l1 (
    .clk_i (clk), .arstn_i (arstn), .a_if (ia1), .b_if (ib1), .busy_o (busy1)
  );

  dual_port_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .OUT_LATENCY (2),
    .RDW_MODE ("write_first"), .INIT_FILE ("")
  ) u_l2 (
    .clk_i (clk), .arstn_i (arstn), .a_if (ia2), .b_if (ib2), .busy_o (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    a_en = 1'b0; a_wr = 1'b0; a_bv = 4'h0; a_addr = '0; a_d = '0;
    b_en = 1'b0; b_wr = 1'b0; b_bv = 4'h0; b_addr = '0; b_d = '0;
  endtask

  task automatic set_a(input logic wr, input logic [3:0] bv, input logic [AW-1:0] addr,
                       input logic [31:0] d);
    a_en = 1'b1; a_wr = wr; a_bv = bv; a_addr = addr; a_d = d;
  endtask

  task automatic set_b(input logic wr, input logic [3:0] bv, input logic [AW-1:0] addr,
                       input logic [31:0] d);
    b_en = 1'b1; b_wr = wr; b_bv = bv; b_addr = addr; b_d = d;
  endtask

  // Counts cycles of busy from the current point; inputs held until busy drops.
  task automatic measure_busy(input string tag);
    int   n;
    logic saw;
    n = 0;
    saw = 1'b0;
    while (busy1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ia1.valid_o || ib1.valid_o || ia2.valid_o || ib2.valid_o) saw = 1'b1;
    end
    idle();
    chk({tag, "_len"}, 32'(n), 32'd16);
    chk({tag, "_no_valid"}, 32'(saw), 32'd0);
    chk({tag, "_busy2_low"}, 32'(busy2), 32'd0);
  endtask

  // Back-to-back A reads of every address against the model.
  task automatic sweep(input string tag);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) set_a(1'b0, 4'h0, AW'(i), 32'h0);
      else idle();
      @(negedge clk);
      if (i < 16) begin
        chk($sformatf("%s_l1_v[%0d]", tag, i), 32'(ia1.valid_o), 32'd1);
        chk($sformatf("%s_l1_d[%0d]", tag, i), ia1.data_o, model[i]);
      end
      if (i >= 1 && i <= 16) begin
        chk($sformatf("%s_l2_v[%0d]", tag, i - 1), 32'(ia2.valid_o), 32'd1);
        chk($sformatf("%s_l2_d[%0d]", tag, i - 1), ia2.data_o, model[i - 1]);
      end
      if (i == 17) chk($sformatf("%s_l2_end", tag), 32'(ia2.valid_o), 32'd0);
    end
  endtask

  initial begin
    idle();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy1", 32'(busy1), 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd1);
    chk("rst_a1_valid", 32'(ia1.valid_o), 32'd0);
    chk("rst_a1_data", ia1.data_o, 32'h0);
    chk("rst_b2_valid", 32'(ib2.valid_o), 32'd0);

    // Clear after release, then every word reads zero
    arstn = 1'b1;
    measure_busy("clear1");
    @(negedge clk);
    sweep("zero");

    // Both ports write addr 5 in one cycle; A wins overlapping bytes
    set_a(1'b1, 4'b0011, AW'(5), 32'h0000_00AA);
    set_b(1'b1, 4'b1111, AW'(5), 32'hBBBB_BBBB);
    @(negedge clk);
    chk("ww_l1_a_valid", 32'(ia1.valid_o), 32'd1);
    chk("ww_l1_a_pre", ia1.data_o, 32'h0);
    chk("ww_l1_b_pre", ib1.data_o, 32'h0);

    // Full write addr 3, read back addr 5 on B
    idle();
    set_a(1'b1, 4'b1111, AW'(3), 32'h1122_3344);
    set_b(1'b0, 4'b0000, AW'(5), 32'h0);
    @(negedge clk);
    chk("ww_l1_b_rd5", ib1.data_o, 32'hBBBB_00AA);

    // Partial write addr 3
    idle();
    set_a(1'b1, 4'b0101, AW'(3), 32'hAABB_CCDD);
    @(negedge clk);
    chk("ww_l2_b_rd5", ib2.data_o, 32'hBBBB_00AA);
    chk("ww_l2_b_v", 32'(ib2.valid_o), 32'd1);
    chk("bw_l1_a_pre", ia1.data_o, 32'h1122_3344);
    chk("bw_l2_a_full", ia2.data_o, 32'h1122_3344);

    // Read addr 3 on B: latency 1 then latency 2
    idle();
    set_b(1'b0, 4'b0000, AW'(3), 32'h0);
    @(negedge clk);
    idle();
    chk("bw_l1_b_v", 32'(ib1.valid_o), 32'd1);
    chk("bw_l1_b_d", ib1.data_o, 32'h11BB_33DD);
    chk("bw_l2_b_early", 32'(ib2.valid_o), 32'd0);
    @(negedge clk);
    chk("bw_l2_b_v", 32'(ib2.valid_o), 32'd1);
    chk("bw_l2_b_d", ib2.data_o, 32'h11BB_33DD);
    chk("bw_l1_b_pulse_end", 32'(ib1.valid_o), 32'd0);
    chk("bw_l1_b_hold", ib1.data_o, 32'h11BB_33DD);

    // Read-during-write on addr 7
    set_a(1'b1, 4'b1111, AW'(7), 32'h1);
    @(negedge clk);
    set_a(1'b1, 4'b1111, AW'(7), 32'h2);
    set_b(1'b0, 4'b0000, AW'(7), 32'h0);
    @(negedge clk);
    idle();
    chk("rdw_l1_b_cross", ib1.data_o, 32'h1);
    chk("rdw_l1_a_rfirst", ia1.data_o, 32'h1);
    @(negedge clk);
    chk("rdw_l2_b_cross", ib2.data_o, 32'h1);
    chk("rdw_l2_a_wfirst", ia2.data_o, 32'h2);

    // Fill with distinct words, then back-to-back sweep
    for (int i = 0; i < 16; i++) begin
      model[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
      set_a(1'b1, 4'b1111, AW'(i), model[i]);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    sweep("fill");

    // Reset with a read in flight: outputs drop at once, pending read is lost
    set_a(1'b0, 4'b0000, AW'(15), 32'h0);
    @(posedge clk);
    #1;
    idle();
    chk("inflight_l1_v", 32'(ia1.valid_o), 32'd1);
    arstn = 1'b0;
    #1;
    chk("arst_l1_v", 32'(ia1.valid_o), 32'd0);
    chk("arst_l1_d", ia1.data_o, 32'h0);
    chk("arst_l2_v", 32'(ia2.valid_o), 32'd0);
    chk("arst_l2_d", ia2.data_o, 32'h0);
    chk("arst_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    arstn = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_clear_busy", 32'(busy1), 32'd1);
    chk("pending_dropped", 32'(ia2.valid_o), 32'd0);

    // Reset at clear count 9, requests held high throughout the restarted clear
    arstn = 1'b0;
    @(negedge clk);
    set_a(1'b1, 4'b1111, AW'(2), 32'hDEAD_BEEF);
    set_b(1'b0, 4'b0000, AW'(15), 32'h0);
    arstn = 1'b1;
    measure_busy("clear2");
    @(negedge clk);
    set_a(1'b0, 4'b0000, AW'(2), 32'h0);
    set_b(1'b0, 4'b0000, AW'(15), 32'h0);
    @(negedge clk);
    idle();
    chk("busy_wr_ignored_l1", ia1.data_o, 32'h0);
    chk("restart_clear_l1", ib1.data_o, 32'h0);
    @(negedge clk);
    chk("busy_wr_ignored_l2", ia2.data_o, 32'h0);
    chk("restart_clear_l2", ib2.data_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dual_port_ram

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8, else elaboration $fatal.
REQ-002 Parameter ADDR_WIDTH, default 8, address bits; depth = 2**ADDR_WIDTH.
REQ-003 Parameter OUT_LATENCY, default 1, read latency in cycles; legal 1 or 2, else $fatal.
REQ-004 Parameter RDW_MODE, default "read_first", same-port read-during-write; legal "read_first", "write_first".
REQ-005 Parameter INIT_FILE, default "", hex image loaded by $readmemh; empty selects hardware clear after reset.
REQ-006 clk_i  in  1  single clock, all ports synchronous to it.
REQ-007 arstn_i  in  1  reset, asynchronous, active-low.
REQ-008 a_en_i / b_en_i  in  1  port access request.
REQ-009 a_wr_i / b_wr_i  in  1  1 = write, 0 = read (qualified by en).
REQ-010 a_byte_valid_i / b_byte_valid_i  in  DATA_WIDTH/8  per-byte write enable, bit i covers bits [8i+7:8i].
REQ-011 a_addr_i / b_addr_i  in  ADDR_WIDTH  word address.
REQ-012 a_data_i / b_data_i  in  DATA_WIDTH  write data.
REQ-013 a_data_o / b_data_o  out  DATA_WIDTH  read data.
REQ-014 a_valid_o / b_valid_o  out  1  one-cycle pulse marking data_o valid.
REQ-015 busy_o  out  1  high while clear sequence runs; requests ignored.

Function
REQ-016 Accepted access = en_i high and busy_o low; no backpressure, one access per port per cycle.
REQ-017 Write: bytes with byte_valid set updated at clock edge; other bytes unchanged; wr with all byte_valid low is a no-op write.
REQ-018 Every accepted access (read or write) SHALL produce valid_o exactly OUT_LATENCY cycles later with the addressed word.
REQ-019 Same-port write, RDW_MODE "read_first": data_o returns pre-write word; "write_first": returns merged post-write word.
REQ-020 Cross-port, same address same cycle, one writing: reading port SHALL return pre-write word in either mode.
REQ-021 Both ports write same address same cycle: per byte, port A wins where both byte_valid set; otherwise each port's bytes land.
REQ-022 data_o SHALL hold last value between valid pulses.
REQ-023 OUT_LATENCY 2: second register stage on data and valid, no bubbles, back-to-back accesses every cycle.
REQ-024 Clear FSM states IDLE, CLEAR, DONE: reset -> CLEAR if INIT_FILE empty else DONE; CLEAR writes zero to address counter, increments each cycle, wraps to DONE after address depth-1; DONE terminal until reset.
REQ-025 Clear takes exactly 2**ADDR_WIDTH cycles after reset release; busy_o high in CLEAR only.
REQ-026 Reads pending in output pipeline at reset assertion are discarded.

Reset
REQ-027 Asynchronous assertion on arstn_i low: data_o = 0, valid_o = 0, clear counter = 0, busy_o = 1 if INIT_FILE empty else 0.
REQ-028 Memory array SHALL NOT be reset; contents retained through reset when INIT_FILE non-empty.
REQ-029 Reset asserted mid-clear SHALL restart clear from address 0 after release.

Structure
REQ-030 Package dual_port_ram_pkg SHALL hold the RDW mode strings as constants and the clear FSM state enum.
REQ-031 Sub-module ram_clear_fsm SHALL own the clear FSM, address counter and busy_o; array, port logic and output pipeline stay in dual_port_ram.
REQ-032 Array SHALL be single always_ff with two write ports, inferable as true dual-port block RAM.

Verification
REQ-033 DATA_WIDTH=32, ADDR_WIDTH=4, INIT_FILE "": release reset -> busy_o high exactly 16 cycles; then read all 16 addresses -> 0x00000000.
REQ-034 Write A addr 3 data 0xAABBCCDD byte_valid 4'b0101 over 0x11223344 -> read B addr 3 returns 0x11BB33DD, valid 1 cycle later (OUT_LATENCY 1), 2 later (OUT_LATENCY 2).
REQ-035 Same cycle A and B write addr 5, A 0x000000AA bv 4'b0011, B 0xBBBBBBBB bv 4'b1111 over zero -> addr 5 reads 0xBBBB00AA.
REQ-036 Addr 7 holds 0x1; A writes 0x2 to addr 7 while B reads addr 7 -> B returns 0x1; repeat same-port write on A -> 0x1 read_first, 0x2 write_first.
REQ-037 Assert arstn_i at clear count 9 -> valid_o, data_o zero immediately; after release busy_o high full 16 cycles; en_i during busy -> no valid_o pulse, no write.
REQ-038 Continuous A reads addr 0..15 every cycle, OUT_LATENCY 2 -> 16 consecutive valid pulses, data in address order, no gaps.
